// File: rtl/buf_fifo_bh.sv
// buf_fifo_bh: first-word-fall-through FIFO buffer register with sticky overflow/underflow flags.
// The oldest word is always visible on R; zero when empty.
module buf_fifo_bh #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic             RD,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] R,
    output logic             EMPTY,
    output logic             FULL,
    output logic [CW-1:0]    COUNT,
    output logic             OVF,
    output logic             UDF
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr, rd;
    logic             push_ok, pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign EMPTY   = COUNT == '0;
    assign FULL    = COUNT == CW'(DEPTH);
    assign R       = EMPTY ? '0 : mem[rd];
    assign push_ok = LOAD & (~FULL | RD);
    assign pop_ok  = RD & ~EMPTY;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr    <= '0;
            rd    <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
            UDF   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (FLUSH) begin
            wr    <= '0;
            rd    <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
            UDF   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr] <= X;
                wr      <= nxt(wr);
            end
            if (pop_ok) rd <= nxt(rd);
            COUNT <= (push_ok && !pop_ok) ? COUNT + 1'b1 :
                     (pop_ok && !push_ok) ? COUNT - 1'b1 : COUNT;
            OVF   <= OVF | (LOAD & FULL & ~RD);
            UDF   <= UDF | (RD & EMPTY);
        end
    end
endmodule

// File: tb/tb_buf_fifo_bh.sv
// tb_buf_fifo_bh: drives a DEPTH=4 and a DEPTH=3 instance with identical stimulus,
// checked against queue-based models of the FIFO rules.
module tb_buf_fifo_bh;
    logic       CLK = 0, CLR = 1, LOAD = 0, RD = 0, FLUSH = 0;
    logic [3:0] X = 0;
    logic [3:0] r_a, r_b;
    logic [2:0] c_a;
    logic [1:0] c_b;
    logic       e_a, f_a, o_a, u_a, e_b, f_b, o_b, u_b;

    int         n_tests = 0, n_fail = 0;
    logic [3:0] q [2][$];
    bit         ovf [2], udf [2];
    int         dep [2] = '{4, 3};

    always #5 CLK = ~CLK;

    buf_fifo_bh #(.WIDTH(4), .DEPTH(4)) dut_a (
        .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .RD(RD), .FLUSH(FLUSH), .X(X),
        .R(r_a), .EMPTY(e_a), .FULL(f_a), .COUNT(c_a), .OVF(o_a), .UDF(u_a)
    );
    buf_fifo_bh #(.WIDTH(4), .DEPTH(3)) dut_b (
        .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .RD(RD), .FLUSH(FLUSH), .X(X),
        .R(r_b), .EMPTY(e_b), .FULL(f_b), .COUNT(c_b), .OVF(o_b), .UDF(u_b)
    );

    function automatic logic [3:0] exp_r(input int i);
        return (q[i].size() != 0) ? q[i][0] : 4'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            ovf[i] = 0;
            udf[i] = 0;
        end
    endtask

    // One clock edge: drive, update both models from pre-edge state, sample 1 time unit later
    task automatic step(input logic l, input logic r, input logic f, input logic [3:0] x);
        LOAD = l; RD = r; FLUSH = f; X = x;
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            int n;
            n = q[i].size();
            if (f) begin
                q[i].delete();
                ovf[i] = 0;
                udf[i] = 0;
            end else begin
                if (l && n == dep[i] && !r) ovf[i] = 1;
                if (r && n == 0) udf[i] = 1;
                if (r && n != 0) void'(q[i].pop_front());
                if (l && (n != dep[i] || r)) q[i].push_back(x);
            end
        end
        #1;
        LOAD = 0; RD = 0; FLUSH = 0;
    endtask

    task automatic test_reset();
        step(0, 0, 1, 0);
        step(1, 0, 0, 4'h3);
        step(1, 0, 0, 4'h5);
        step(1, 0, 0, 4'h9);
        step(0, 1, 0, 0);
        #2 CLR = 1;
        #1;
        model_clear();
        n_tests++;
        if ({r_a, c_a, e_a, f_a, o_a, u_a} !== {4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_d4 got r=%h c=%0d e=%b f=%b o=%b u=%b want 0 0 1 0 0 0", r_a, c_a, e_a, f_a, o_a, u_a);
        end
        n_tests++;
        if ({r_b, c_b, e_b, f_b, o_b, u_b} !== {4'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_d3 got r=%h c=%0d e=%b f=%b o=%b u=%b want 0 0 1 0 0 0", r_b, c_b, e_b, f_b, o_b, u_b);
        end
        @(negedge CLK) CLR = 0;
        @(negedge CLK);
    endtask

    task automatic test_fill_drain();
        logic [3:0] ins [4] = '{4'h3, 4'h5, 4'h9, 4'hC};
        logic [3:0] outs [4] = '{4'h5, 4'h9, 4'hC, 4'h0};
        foreach (ins[k]) step(1, 0, 0, ins[k]);
        n_tests++;
        if ({f_a, c_a, r_a} !== {1'b1, 3'd4, 4'h3}) begin
            n_fail++;
            $display("FAIL fill_d4 got f=%b c=%0d r=%h want 1 4 3", f_a, c_a, r_a);
        end
        n_tests++;
        if ({f_b, c_b, r_b, o_b} !== {1'b1, 2'd3, 4'h3, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_d3 got f=%b c=%0d r=%h o=%b want 1 3 3 1", f_b, c_b, r_b, o_b);
        end
        foreach (outs[k]) begin
            step(0, 1, 0, 0);
            n_tests++;
            if (r_a !== outs[k]) begin
                n_fail++;
                $display("FAIL drain_d4[%0d] got r=%h want %h", k, r_a, outs[k]);
            end
        end
        n_tests++;
        if ({e_a, c_a, u_a} !== {1'b1, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL drained_d4 got e=%b c=%0d u=%b want 1 0 0", e_a, c_a, u_a);
        end
        n_tests++;
        if ({e_b, u_b, r_b} !== {1'b1, 1'b1, 4'h0}) begin
            n_fail++;
            $display("FAIL drained_d3 got e=%b u=%b r=%h want 1 1 0", e_b, u_b, r_b);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] ins [4] = '{4'h3, 4'h5, 4'h9, 4'hC};
        step(0, 0, 1, 0);
        foreach (ins[k]) step(1, 0, 0, ins[k]);
        step(1, 0, 0, 4'hF);
        n_tests++;
        if ({o_a, c_a, r_a, f_a} !== {1'b1, 3'd4, 4'h3, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_d4 got o=%b c=%0d r=%h f=%b want 1 4 3 1", o_a, c_a, r_a, f_a);
        end
        foreach (ins[k]) begin
            n_tests++;
            if (r_a !== ins[k]) begin
                n_fail++;
                $display("FAIL ovf_drain_d4[%0d] got r=%h want %h", k, r_a, ins[k]);
            end
            step(0, 1, 0, 0);
        end
    endtask

    task automatic test_underflow();
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        n_tests++;
        if ({u_a, c_a, e_a} !== {1'b1, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL udf_d4 got u=%b c=%0d e=%b want 1 0 1", u_a, c_a, e_a);
        end
        step(1, 1, 0, 4'h7);
        n_tests++;
        if ({c_a, r_a, u_a, e_a} !== {3'd1, 4'h7, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL udf_push_d4 got c=%0d r=%h u=%b e=%b want 1 7 1 0", c_a, r_a, u_a, e_a);
        end
        n_tests++;
        if ({c_b, r_b, u_b} !== {2'd1, 4'h7, 1'b1}) begin
            n_fail++;
            $display("FAIL udf_push_d3 got c=%0d r=%h u=%b want 1 7 1", c_b, r_b, u_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] outs_a [4] = '{4'hC, 4'hD, 4'hE, 4'hF};
        logic [3:0] outs_b [3] = '{4'hD, 4'hE, 4'hF};
        step(0, 0, 1, 0);
        for (int k = 1; k <= 4; k++) step(1, 0, 0, 4'(k));
        for (int k = 10; k <= 15; k++) begin
            step(1, 1, 0, 4'(k));
            n_tests++;
            if ({c_a, f_a} !== {3'd4, 1'b1}) begin
                n_fail++;
                $display("FAIL b2b_d4 x=%h got c=%0d f=%b want 4 1", k, c_a, f_a);
            end
        end
        foreach (outs_a[k]) begin
            n_tests++;
            if (r_a !== outs_a[k] || (k < 3 && r_b !== outs_b[k])) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d] got a=%h b=%h want a=%h", k, r_a, r_b, outs_a[k]);
            end
            step(0, 1, 0, 0);
        end
    endtask

    task automatic test_flush();
        step(0, 0, 1, 0);
        foreach (dep[i]) ;
        step(1, 0, 0, 4'h1);
        step(1, 0, 0, 4'h2);
        step(1, 0, 0, 4'h6);
        step(1, 0, 0, 4'h8);
        step(1, 0, 0, 4'h4);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        n_tests++;
        if ({c_a, r_a, o_a} !== {3'd2, 4'h6, 1'b1}) begin
            n_fail++;
            $display("FAIL preflush_d4 got c=%0d r=%h o=%b want 2 6 1", c_a, r_a, o_a);
        end
        step(1, 1, 1, 4'hB);
        n_tests++;
        if ({c_a, e_a, o_a, u_a, r_a} !== {3'd0, 1'b1, 1'b0, 1'b0, 4'h0}) begin
            n_fail++;
            $display("FAIL flush_d4 got c=%0d e=%b o=%b u=%b r=%h want 0 1 0 0 0", c_a, e_a, o_a, u_a, r_a);
        end
        n_tests++;
        if ({c_b, e_b, o_b} !== {2'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_d3 got c=%0d e=%b o=%b want 0 1 0", c_b, e_b, o_b);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0, 4'($urandom));
            n_tests++;
            if ({r_a, c_a, o_a, u_a, e_a, f_a} !== {exp_r(0), 3'(q[0].size()), ovf[0], udf[0],
                                                    q[0].size() == 0, q[0].size() == 4}) begin
                n_fail++;
                $display("FAIL rand_d4 step %0d got r=%h c=%0d o=%b u=%b want r=%h c=%0d o=%b u=%b",
                         k, r_a, c_a, o_a, u_a, exp_r(0), q[0].size(), ovf[0], udf[0]);
            end
            n_tests++;
            if ({r_b, c_b, o_b, u_b, e_b, f_b} !== {exp_r(1), 2'(q[1].size()), ovf[1], udf[1],
                                                    q[1].size() == 0, q[1].size() == 3}) begin
                n_fail++;
                $display("FAIL rand_d3 step %0d got r=%h c=%0d o=%b u=%b want r=%h c=%0d o=%b u=%b",
                         k, r_b, c_b, o_b, u_b, exp_r(1), q[1].size(), ovf[1], udf[1]);
            end
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge CLK);
        CLR = 0;
        @(negedge CLK);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/buf_fifo_bh.md
Name: buf_fifo_bh

Overview:
- Parametrised successor to the SAP-1 single-entry buffer register.
- Holds up to DEPTH words of WIDTH bits in first-in/first-out order, so a producer (input port, keyboard encoder) can run ahead of the consumer (bus/output register).
- First-word-fall-through: the oldest word is always visible on R.
- Status and sticky error flags let the controller sequence transfers.

Parameters:
- WIDTH, 4, data word width in bits (>=1)
- DEPTH, 4, number of storage entries (>=2, need not be a power of two)
- CW, $clog2(DEPTH+1), width of COUNT (derived, not overridden)

Ports:
- CLK  input  1  clock, all state updates on rising edge
- CLR  input  1  asynchronous active-high reset
- LOAD  input  1  push request: write X at tail on this edge
- RD  input  1  pop request: discard head word on this edge
- FLUSH  input  1  synchronous empty-and-clear-flags
- X  input  WIDTH  write data
- R  output  WIDTH  head-of-queue data (FWFT)
- EMPTY  output  1  high when COUNT==0
- FULL  output  1  high when COUNT==DEPTH
- COUNT  output  CW  number of valid entries, 0..DEPTH
- OVF  output  1  sticky: push attempted while full and not popping
- UDF  output  1  sticky: pop attempted while empty

Behaviour:
- Reset: CLR is asynchronous, active-high; clock CLK. While CLR=1:
  - write/read pointers=0, COUNT=0, OVF=0, UDF=0
  - all storage entries=0
  - hence R=0, EMPTY=1, FULL=0
- State is held in registers: write pointer, read pointer, COUNT, storage array, OVF, UDF.
- Outputs:
  - EMPTY and FULL are decoded combinationally from COUNT.
  - R = storage[read pointer] when EMPTY=0, otherwise all zeros.
  - R is combinational from registered state, so it reflects a push into an empty FIFO in the same cycle the write occurs, i.e. the cycle after the LOAD edge.
- Per rising edge (CLR=0), evaluated in priority order:
  1. FLUSH=1: pointers=0, COUNT=0, OVF=0, UDF=0. Storage is not cleared. LOAD and RD are ignored.
  2. Otherwise, push_ok = LOAD & (~FULL | RD) and pop_ok = RD & ~EMPTY.
     - push_ok: storage[wr]<=X; wr advances.
     - pop_ok: rd advances.
     - COUNT: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
     - Full case: LOAD&RD while FULL performs both; the new word goes into the slot being vacated. COUNT stays DEPTH.
     - Empty case: LOAD&RD while EMPTY performs the push only. The pop is ignored, COUNT becomes 1 and UDF sets. There is no pass-through of X.
- Sticky flags:
  - OVF sets on LOAD & FULL & ~RD. The dropped word is lost and contents are unchanged.
  - UDF sets on RD & EMPTY. State is otherwise unchanged.
  - Both hold until CLR or FLUSH.
- Pointer wrap: each pointer increments modulo DEPTH (DEPTH-1 -> 0), including non-power-of-two DEPTH. COUNT never exceeds DEPTH or goes below 0.
- Latency:
  - Write-to-R: 1 edge when the FIFO is empty.
  - Pop-to-next-word on R: 1 edge.
- Reset mid-operation: asserting CLR at any time, including between edges, immediately forces the reset values above. Contents are lost.
- Single clock domain; no combinational path from LOAD/RD to any output.

Test Plan:
- Reset (WIDTH=4, DEPTH=4): assert CLR with prior contents -> R=0, COUNT=0, EMPTY=1, FULL=0, OVF=UDF=0 without a clock edge.
- Fill/drain: push 0x3,0x5,0x9,0xC on 4 edges -> FULL=1, COUNT=4, R=0x3. Then RD on 4 edges -> R shows 0x5,0x9,0xC, then 0 with EMPTY=1.
- Overflow: full with 0x3,0x5,0x9,0xC, LOAD X=0xF alone -> OVF=1, COUNT=4, contents unchanged. Drain order is still 0x3..0xC.
- Underflow:
  - RD on empty -> UDF=1, COUNT=0.
  - Then LOAD&RD with X=0x7 on empty -> COUNT=1, R=0x7, UDF stays 1.
- Simultaneous at full plus wrap: full 0x1,0x2,0x3,0x4, then LOAD&RD with X=0xA for 6 edges using 0xA..0xF -> COUNT stays 4, FULL=1. Drain yields 0xC,0xD,0xE,0xF, proving pointer wrap.
- Flush/reset priority:
  - Contents 0x6,0x8 with OVF=1: FLUSH&LOAD&RD -> COUNT=0, EMPTY=1, OVF=0.
  - Repeat the test with DEPTH=3: pointer wrap 2->0 passes.
  - CLR pulsed between edges mid-drain -> immediate reset values.
